// File: rtl/mul_mid_pkg.sv
// Shared types, default widths and parameter checking for the iterative
// middle-bit multiplier.
package mul_mid_pkg;

    localparam int unsigned MUL_SIZE_DEF = 80;
    localparam int unsigned LIMB_W_DEF   = 20;
    localparam int unsigned RADIX_DEF    = 78;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Limb count for a legal parameter set; 0 flags an illegal one.
    function automatic int unsigned calc_limbs(input int unsigned mul_size,
                                               input int unsigned limb_w,
                                               input int unsigned radix);
        if (limb_w == 0 || (mul_size % limb_w) != 0 || radix < 1 || radix > mul_size)
            return 0;
        return mul_size / limb_w;
    endfunction

endpackage

// File: rtl/mul_row_unit.sv
// One a-limb times every b-limb, summed and shifted into row position.
// Holds the LIMBS limb multipliers of the datapath.
module mul_row_unit #(
    parameter int unsigned MUL_SIZE = 80,
    parameter int unsigned LIMB_W   = 20,
    parameter int unsigned ROW_W    = 2
) (
    input  logic [LIMB_W-1:0]     a_limb,
    input  logic [MUL_SIZE-1:0]   b,
    input  logic [ROW_W-1:0]      row,
    output logic [2*MUL_SIZE-1:0] row_sum
);

    localparam int unsigned LIMBS = MUL_SIZE / LIMB_W;
    localparam int unsigned PW    = 2 * MUL_SIZE;
    localparam int unsigned DW    = 2 * LIMB_W;

    logic [DW-1:0] prod [LIMBS];
    logic [PW-1:0] partial;

    always_comb begin
        partial = '0;
        for (int unsigned j = 0; j < LIMBS; j++) begin
            prod[j] = DW'(a_limb) * DW'(b[j*LIMB_W +: LIMB_W]);
            partial = partial + (PW'(prod[j]) << (LIMB_W * j));
        end
        row_sum = partial << (LIMB_W * row);
    end

endmodule

// File: rtl/mul_mid_bits_iter.sv
// Iterative MUL_SIZE x MUL_SIZE multiplier returning P[2*RADIX-1:RADIX];
// one a-limb row per cycle, valid/ready on both sides, synchronous flush.
module mul_mid_bits_iter
    import mul_mid_pkg::*;
#(
    parameter int unsigned MUL_SIZE = MUL_SIZE_DEF,
    parameter int unsigned LIMB_W   = LIMB_W_DEF,
    parameter int unsigned RADIX    = RADIX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MUL_SIZE-1:0] a,
    input  logic [MUL_SIZE-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RADIX-1:0]    res,
    output logic                busy
);

    localparam int unsigned LIMBS = calc_limbs(MUL_SIZE, LIMB_W, RADIX);
    localparam int unsigned ROW_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam int unsigned PW    = 2 * MUL_SIZE;

    if (LIMBS == 0) begin : g_bad_params
        $error("mul_mid_bits_iter: need MUL_SIZE %% LIMB_W == 0 and 1 <= RADIX <= MUL_SIZE");
    end

    state_t              state;
    state_t              next_state;
    logic [MUL_SIZE-1:0] a_reg;
    logic [MUL_SIZE-1:0] b_reg;
    logic [PW-1:0]       acc;
    logic [ROW_W-1:0]    row;
    logic [LIMB_W-1:0]   a_limb;
    logic [PW-1:0]       row_sum;

    assign a_limb = LIMB_W'(a_reg >> (LIMB_W * row));

    mul_row_unit #(
        .MUL_SIZE (MUL_SIZE),
        .LIMB_W   (LIMB_W),
        .ROW_W    (ROW_W)
    ) u_row (
        .a_limb  (a_limb),
        .b       (b_reg),
        .row     (row),
        .row_sum (row_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // flush overrides both handshakes
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = MUL;
            MUL:     if (row == ROW_W'(LIMBS - 1)) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // Handshake flags are registered copies of the state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            busy      <= (next_state != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            row   <= '0;
        end else if (flush) begin
            acc <= '0;
            row <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= a;
                    b_reg <= b;
                    acc   <= '0;
                    row   <= '0;
                end
                MUL: begin
                    acc <= acc + row_sum;
                    row <= row + ROW_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign res = acc[2*RADIX-1:RADIX];

endmodule

// File: tb/tb_mul_mid_bits_iter.sv
// Scoreboard bench for mul_mid_bits_iter: default 80/20/78 instance plus
// 64/16/60 and 40/20/20 instances for the parameter sweep.
module tb_mul_mid_bits_iter;

    logic clk;
    logic rst_n;
    logic flush;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [79:0] a, b;
    logic [77:0] res;

    logic        v64, ir64, ov64, r64, bz64;
    logic [63:0] a64, b64;
    logic [59:0] res64;

    logic        v40, ir40, ov40, r40, bz40;
    logic [39:0] a40, b40;
    logic [19:0] res40;

    logic [77:0] sbq[$];
    logic [59:0] q64[$];
    logic [19:0] q40[$];

    int checks;
    int errors;

    mul_mid_bits_iter u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res), .busy(busy)
    );

    mul_mid_bits_iter #(.MUL_SIZE(64), .LIMB_W(16), .RADIX(60)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v64), .in_ready(ir64),
        .a(a64), .b(b64), .out_valid(ov64), .out_ready(r64), .res(res64), .busy(bz64)
    );

    mul_mid_bits_iter #(.MUL_SIZE(40), .LIMB_W(20), .RADIX(20)) u_dut40 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v40), .in_ready(ir40),
        .a(a40), .b(b40), .out_valid(ov40), .out_ready(r40), .res(res40), .busy(bz40)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [77:0] mid80(input logic [79:0] x, input logic [79:0] y);
        logic [159:0] p;
        p = {80'd0, x} * {80'd0, y};
        return p[155:78];
    endfunction

    function automatic logic [59:0] mid64(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] p;
        p = {64'd0, x} * {64'd0, y};
        return p[119:60];
    endfunction

    function automatic logic [19:0] mid40(input logic [39:0] x, input logic [39:0] y);
        logic [79:0] p;
        p = {40'd0, x} * {40'd0, y};
        return p[39:20];
    endfunction

    function automatic logic [79:0] rnd80();
        return 80'({$urandom, $urandom, $urandom});
    endfunction

    // Handshake one operand pair into the default DUT and wait for its result.
    // Returns at the negedge where out_valid is first seen.
    task automatic do_op(input logic [79:0] av, input logic [79:0] bv,
                         output logic [77:0] exp_res, output time t_acc);
        int n;
        int edges;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        sbq.push_back(mid80(av, bv));
        @(posedge clk);
        t_acc = $time;
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && edges < 40) begin
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_flags: in_ready=%b busy=%b, required 0/1", in_ready, busy);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checks++;
        if (edges != 5) begin
            errors++;
            $display("FAIL latency80: %0d edges, required 5", edges);
        end
        exp_res = sbq.pop_front();
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL result80: a=%h b=%h res=%h required %h", av, bv, res, exp_res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        v64 = 1'b0; r64 = 1'b1; a64 = '0; b64 = '0;
        v40 = 1'b0; r40 = 1'b1; a40 = '0; b40 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (res !== 78'd0) begin
            errors++;
            $display("FAIL reset_res: res=%h required 0", res);
        end
    endtask

    task automatic test_basic();
        logic [79:0] p78;
        logic [77:0] e;
        time t;
        p78 = 80'd1 << 78;
        out_ready = 1'b1;
        do_op(p78, 80'd1, e, t);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_return_idle: out_valid=%b in_ready=%b busy=%b, required 0/1/0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_patterns();
        logic [79:0] p40;
        logic [79:0] p38;
        logic [77:0] e;
        time t;
        p40 = 80'd1 << 40;
        p38 = 80'd1 << 38;
        out_ready = 1'b1;
        do_op('1, '1, e, t);
        do_op(p40, p38, e, t);
        do_op(80'd0, rnd80(), e, t);
        for (int i = 0; i < 4; i++) do_op(rnd80(), rnd80(), e, t);
    endtask

    task automatic test_back_to_back();
        time t_prev;
        time t_now;
        logic [77:0] e;
        out_ready = 1'b1;
        do_op(rnd80(), rnd80(), e, t_prev);
        for (int i = 0; i < 4; i++) begin
            do_op(rnd80(), rnd80(), e, t_now);
            checks++;
            if (t_now - t_prev != 60) begin
                errors++;
                $display("FAIL throughput: accept spacing %0t, required 60", t_now - t_prev);
            end
            t_prev = t_now;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [77:0] e;
        time t;
        out_ready = 1'b0;
        do_op(rnd80(), rnd80(), e, t);
        for (int i = 0; i < 10; i++) begin
            a = rnd80();
            b = rnd80();
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (res !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: res=%h out_valid=%b in_ready=%b, required %h/1/0",
                         res, out_valid, in_ready, e);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0/1",
                     out_valid, in_ready);
        end
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_no_queue: out_valid=%b busy=%b, required 0/0",
                         out_valid, busy);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [77:0] e;
        time t;
        out_ready = 1'b1;
        a = 80'd1 << 78;
        b = 80'd1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
                     in_ready, out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(80'd3, 80'd5, e, t);
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [77:0] e;
        time t;
        out_ready = 1'b1;
        // flush beats an IDLE input handshake
        a = rnd80();
        b = rnd80();
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: busy=%b in_ready=%b, required 0/1", busy, in_ready);
        end
        // flush during MUL row 1
        a = '1;
        b = '1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_mul: in_ready=%b busy=%b out_valid=%b, required 1/0/0",
                     in_ready, busy, out_valid);
        end
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_mul_no_result: out_valid=%b required 0", out_valid);
            end
        end
        // flush together with out_ready in DONE
        out_ready = 1'b0;
        do_op(rnd80(), rnd80(), e, t);
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b busy=%b, required 0/1/0",
                     out_valid, in_ready, busy);
        end
        out_ready = 1'b1;
        do_op(rnd80(), rnd80(), e, t);
        @(negedge clk);
    endtask

    task automatic test_sweep_64();
        logic [63:0] av, bv;
        logic [59:0] e;
        int n;
        int edges;
        r64 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            av = (i == 0) ? '1 : 64'({$urandom, $urandom});
            bv = (i == 0) ? '1 : 64'({$urandom, $urandom});
            n = 0;
            while (ir64 !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            a64 = av;
            b64 = bv;
            v64 = 1'b1;
            q64.push_back(mid64(av, bv));
            @(posedge clk);
            edges = 1;
            @(negedge clk);
            v64 = 1'b0;
            while (ov64 !== 1'b1 && edges < 40) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            checks++;
            if (edges != 5) begin
                errors++;
                $display("FAIL latency64: %0d edges, required 5", edges);
            end
            e = q64.pop_front();
            checks++;
            if (res64 !== e) begin
                errors++;
                $display("FAIL result64: a=%h b=%h res=%h required %h", av, bv, res64, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sweep_40();
        logic [39:0] av, bv;
        logic [19:0] e;
        int n;
        int edges;
        r40 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            av = (i == 0) ? '1 : 40'({$urandom, $urandom});
            bv = (i == 0) ? '1 : 40'({$urandom, $urandom});
            n = 0;
            while (ir40 !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            a40 = av;
            b40 = bv;
            v40 = 1'b1;
            q40.push_back(mid40(av, bv));
            @(posedge clk);
            edges = 1;
            @(negedge clk);
            v40 = 1'b0;
            while (ov40 !== 1'b1 && edges < 40) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            checks++;
            if (edges != 3) begin
                errors++;
                $display("FAIL latency40: %0d edges, required 3", edges);
            end
            e = q40.pop_front();
            checks++;
            if (res40 !== e) begin
                errors++;
                $display("FAIL result40: a=%h b=%h res=%h required %h", av, bv, res40, e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_flush();
        test_sweep_64();
        test_sweep_40();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_mid_bits_iter.md
Name: mul_mid_bits_iter

Overview:
- Parametrised, iterative successor to the fixed 80-bit middle-bit multiplier.
- Computes P = a*b over MUL_SIZE-bit unsigned operands and returns the middle slice P[2*RADIX-1:RADIX].
- Processes one a-limb per cycle against all b-limbs, so it uses LIMBS multipliers instead of LIMBS^2.
- Adds valid/ready handshakes on input and output, plus a synchronous flush; sits in the modular-reduction datapath.

Parameters:
- MUL_SIZE, 80: operand width in bits.
- LIMB_W, 20: limb width; each limb product maps to one DSP.
- RADIX, 78: output slice offset; output width is RADIX.
- LIMBS (localparam), MUL_SIZE/LIMB_W: number of limbs per operand.
- Elaboration constraints: MUL_SIZE % LIMB_W == 0; 1 <= RADIX <= MUL_SIZE. Violation is a $error at elaboration.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  MUL_SIZE  multiplicand.
- b  in  MUL_SIZE  multiplier.
- out_valid  out  1  res holds a completed result.
- out_ready  in  1  consumer accepts res.
- res  out  RADIX  P[2*RADIX-1:RADIX].
- busy  out  1  high in MUL or DONE.

Behaviour:
- Reset: rst_n low asynchronously clears state to IDLE, the row counter, a_reg, b_reg and the 2*MUL_SIZE-bit accumulator acc.
  - After reset: in_ready=1, out_valid=0, busy=0, res=0.
  - Reset asserted mid-operation discards the operation; no partial result is ever emitted.
- States: IDLE, MUL, DONE. The state register is the only source of in_ready, out_valid and busy; all three are registered-state decodes.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_reg=a, b_reg=b, acc=0, row=0, go to MUL.
  - in_valid low: stay in IDLE.
- MUL:
  - Each cycle: acc <= acc + (sum over j of a_reg[row]*b_reg[j] << LIMB_W*(row+j)); row <= row+1.
  - When row==LIMBS-1, that update is the last; go to DONE.
  - Exactly LIMBS cycles are spent in MUL.
  - Each limb product is LIMB_W*2 bits. The row sum and acc are 2*MUL_SIZE bits. No overflow is possible because the final acc equals a*b exactly.
- DONE:
  - out_valid=1; res = acc[2*RADIX-1:RADIX].
  - res is stable while out_valid && !out_ready (back-pressure holds indefinitely).
  - On out_valid&&out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle accept.
- Latency: out_valid rises LIMBS+1 clock edges after the input handshake edge, i.e. 5 edges for the defaults.
- Throughput: one result per LIMBS+2 cycles when out_ready is held high.
- flush:
  - In any state, go to IDLE next edge, clear acc and row, drop out_valid.
  - flush has priority over a same-cycle in_valid or out_ready handshake; neither handshake completes.
- res is driven only from acc. Between results, in IDLE and MUL, res shows acc's slice, which is unspecified.
- The bench samples res only when out_valid=1.
- in_valid while busy is ignored; in_ready=0. Operands are not queued.

Decomposition:
- Package mul_mid_pkg:
  - State encoding localparams: IDLE=2'd0, MUL=2'd1, DONE=2'd2.
  - Default widths.
  - A function computing LIMBS and checking the constraints.
- Sub-module mul_row_unit:
  - Combinational.
  - Inputs: one LIMB_W a-limb, the full b_reg, and the row index.
  - Output: the 2*MUL_SIZE-bit shifted row sum.
  - Instantiated once; holds the LIMBS DSP multipliers.
- Top level holds the FSM, operand registers, accumulator and handshakes.

Test Plan:
1. Reset then a=2^78, b=1, out_ready=1 -> out_valid exactly 5 edges after the handshake; res=1; in_ready=0 during MUL/DONE.
2. a=b=2^80-1 -> res=2^78-8. Also a=2^40, b=2^38 -> res=1 (cross-limb shift check).
3. Hold out_ready=0 for 10 cycles in DONE, apply new in_valid -> res stable, in_ready=0, new operands ignored. Release out_ready -> in_ready=1 next cycle.
4. Assert rst_n=0 asynchronously (between edges) during MUL row 2 -> in_ready=1, out_valid=0, busy=0 immediately. The next operation (a=3, b=5) yields the correct P[155:78]=0.
5. flush in MUL row 1 and flush coincident with out_ready in DONE -> IDLE next edge, no result handshake counted.
6. Parameter sweep: MUL_SIZE=64, LIMB_W=16, RADIX=60 and MUL_SIZE=40, LIMB_W=20, RADIX=20, 1000 random operands each -> res matches a reference-model slice. Latency equals LIMBS+1.
